funct_gen_sequencer: RTL and testbench
======================================

Name: funct_gen_sequencer

Overview:
Controller that sequences the function-generator sample memory. It owns the memory address counter and runs two modes. CONFIG loads a waveform of up to 2^ADDR_W samples into the memory. GEN plays the stored waveform into the downstream FIFO, honouring FIFO-full backpressure, for a programmed number of passes or continuously. It sits between the host/config interface, the sample RAM and the output FIFO, and replaces ad-hoc enable/clear strobes with one arbitrated sequencer.

Parameters:
DATA_W, 8, sample width
ADDR_W, 6, sample memory address width (depth 2^ADDR_W)
REP_W, 8, pass-count width; value 0 means continuous

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cfg_start_i  in  1  pulse: begin waveform load
cfg_last_i  in  ADDR_W  last sample address of waveform, sampled with cfg_start_i
cfg_we_i  in  1  config sample valid
cfg_data_i  in  DATA_W  config sample
gen_start_i  in  1  pulse: begin playback
gen_stop_i  in  1  abort playback
rep_i  in  REP_W  pass count, sampled with gen_start_i
mem_we_o  out  1  sample RAM write enable
mem_addr_o  out  ADDR_W  sample RAM address
mem_wdata_o  out  DATA_W  sample RAM write data
mem_rdata_i  in  DATA_W  sample RAM read data, synchronous, 1-cycle latency
fifo_full_i  in  1  downstream FIFO full
fifo_push_o  out  1  FIFO push
fifo_data_o  out  DATA_W  FIFO write data
busy_o  out  1  state != IDLE
done_o  out  1  1-cycle pulse at playback completion
err_o  out  1  1-cycle pulse on illegal request

Behaviour:
- Reset (rst=0, async): state=IDLE, addr=0, last=0, rep_cnt=0, cfg_valid=0. All outputs are 0.
- States: IDLE, CONFIG, FETCH, PUSH, DONE.
- IDLE, cfg_start_i=1: latch last=cfg_last_i, addr=0, go to CONFIG. cfg_start_i has priority over a simultaneous gen_start_i.
- IDLE, gen_start_i=1:
  - If cfg_valid=1: latch rep=rep_i, rep_cnt=0, addr=0, go to FETCH.
  - If cfg_valid=0: pulse err_o, stay in IDLE.
- CONFIG:
  - mem_we_o = cfg_we_i (combinational); mem_wdata_o = cfg_data_i; mem_addr_o = addr.
  - Each accepted write increments addr.
  - The write at addr==last sets cfg_valid=1, clears addr to 0 and returns to IDLE on the next cycle.
  - Gaps in cfg_we_i are allowed.
- FETCH: mem_addr_o = addr (read issued). Next state is PUSH.
- PUSH:
  - mem_rdata_i is valid and held stable because addr is unchanged.
  - fifo_push_o = !fifo_full_i && !gen_stop_i (combinational); fifo_data_o = mem_rdata_i.
  - While full: stay in PUSH with no push.
  - On push with addr!=last: addr+1, go to FETCH.
  - On push with addr==last: addr=0, rep_cnt+1.
    - If rep!=0 and rep_cnt+1==rep: go to DONE.
    - Otherwise: go to FETCH (wrap-around).
- Throughput: 1 sample per 2 cycles when the FIFO is not full.
- DONE: done_o=1 for this cycle, then IDLE.
- gen_stop_i in FETCH or PUSH: go to IDLE next cycle. No push in that cycle. done_o stays 0.
- cfg_start_i or gen_start_i outside IDLE: ignored, err_o pulses, current operation continues.
- cfg_last_i=0 gives a 1-sample waveform.
- rep_i=0 means infinite playback until gen_stop_i.
- mem_we_o=0 in all states except CONFIG. fifo_push_o=0 in all states except PUSH.
- Async reset mid-CONFIG clears cfg_valid; a subsequent gen_start_i raises err_o.

Decomposition:
- Package funct_gen_pkg: state_t enum {IDLE, CONFIG, FETCH, PUSH, DONE}; DATA_W/ADDR_W/REP_W defaults.
- Sub-module funct_gen_addr_cnt: address counter with clear, increment, terminal flag addr==last. Reused for the CONFIG and GEN address paths.

Test Plan:
1. Reset, then load 4 samples: cfg_start with last=3, writes 0x10, 0x20, 0x30, 0x40 -> mem_we at addr 0..3, busy drops the cycle after the 4th write, cfg_valid=1.
2. gen_start with rep=2, FIFO never full -> 8 pushes, data 10, 20, 30, 40, 10, 20, 30, 40, one push every 2 cycles, then done_o single pulse, busy_o=0.
3. rep=1, fifo_full held high for 5 cycles on the 2nd sample -> no push while full, 0x20 pushed exactly once after full drops, sample order preserved.
4. rep=0, gen_stop asserted after 6 pushes -> no further pushes, IDLE next cycle, done_o never asserted.
5. gen_start right after reset with no config -> err_o pulse, stays IDLE. Simultaneous cfg_start+gen_start in IDLE -> CONFIG entered.
6. rst low mid-GEN (addr=2) -> outputs 0 immediately. After rst release, gen_start -> err_o, because cfg_valid was cleared.

Source files
------------

// File: rtl/funct_gen_pkg.sv
// funct_gen_pkg: shared state encoding and default widths for the function-generator sequencer.
package funct_gen_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 6;
   localparam int DEF_REP_W  = 8;
   typedef enum logic [2:0] {IDLE, CONFIG, FETCH, PUSH, DONE} state_t;
endpackage

// File: rtl/funct_gen_addr_cnt.sv
// funct_gen_addr_cnt: sample address counter with clear, increment and addr==last terminal flag.
module funct_gen_addr_cnt #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] last,
   output logic [W-1:0] addr,
   output logic         term
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) addr <= '0;
      else if (clr) addr <= '0;
      else if (inc) addr <= addr + 1'b1;
   assign term = addr == last;
endmodule

// File: rtl/funct_gen_sequencer.sv
// funct_gen_sequencer: loads a waveform into sample RAM and plays it into the output FIFO.
module funct_gen_sequencer
   import funct_gen_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int REP_W  = DEF_REP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start_i,
   input  logic [ADDR_W-1:0] cfg_last_i,
   input  logic              cfg_we_i,
   input  logic [DATA_W-1:0] cfg_data_i,
   input  logic              gen_start_i,
   input  logic              gen_stop_i,
   input  logic [REP_W-1:0]  rep_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              fifo_full_i,
   output logic              fifo_push_o,
   output logic [DATA_W-1:0] fifo_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] last, addr;
   logic [REP_W-1:0]  rep, rep_cnt, rep_nxt;
   logic              cfg_valid, term, clr, inc, wr, push, start_cfg, start_gen;

   assign start_cfg = state == IDLE && cfg_start_i;
   assign start_gen = state == IDLE && gen_start_i && !cfg_start_i && cfg_valid;
   assign wr        = state == CONFIG && cfg_we_i;
   assign push      = state == PUSH && !fifo_full_i && !gen_stop_i;
   assign clr       = start_cfg || start_gen || ((wr || push) && term);
   assign inc       = (wr || push) && !term;
   assign rep_nxt   = rep_cnt + 1'b1;

   funct_gen_addr_cnt #(.W(ADDR_W)) u_addr (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (inc),
      .last (last),
      .addr (addr),
      .term (term)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;

   // a new load invalidates the stored waveform until its last sample lands
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         last      <= '0;
         rep       <= '0;
         rep_cnt   <= '0;
         cfg_valid <= 1'b0;
      end else begin
         if (start_cfg) begin
            last      <= cfg_last_i;
            cfg_valid <= 1'b0;
         end
         if (wr && term) cfg_valid <= 1'b1;
         if (start_gen) begin
            rep     <= rep_i;
            rep_cnt <= '0;
         end
         if (push && term) rep_cnt <= rep_nxt;
      end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start_cfg ? CONFIG : start_gen ? FETCH : IDLE;
         CONFIG:  state_nxt = wr && term ? IDLE : CONFIG;
         FETCH:   state_nxt = gen_stop_i ? IDLE : PUSH;
         PUSH:    state_nxt = gen_stop_i ? IDLE : !push ? PUSH :
                              term && |rep && rep_nxt == rep ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_we_o    = wr;
      mem_addr_o  = addr;
      mem_wdata_o = state == CONFIG ? cfg_data_i : '0;
      fifo_push_o = push;
      fifo_data_o = push ? mem_rdata_i : '0;
      busy_o      = state != IDLE;
      done_o      = state == DONE;
      err_o       = state == IDLE ? gen_start_i && !cfg_start_i && !cfg_valid
                                  : cfg_start_i || gen_start_i;
   end
endmodule

// File: tb/tb_funct_gen_sequencer.sv
// tb_funct_gen_sequencer: directed scenarios against a behavioural sample RAM with push/done monitors.
module tb_funct_gen_sequencer;
   logic       clk = 0, rst = 0;
   logic       cfg_start = 0, cfg_we = 0, gen_start = 0, gen_stop = 0, fifo_full = 0;
   logic [5:0] cfg_last = 0;
   logic [7:0] cfg_data = 0, rep = 0;
   logic       mem_we, fifo_push, busy, done, err;
   logic [5:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata = 0, fifo_data;
   logic [7:0] ram [64];
   logic [7:0] wave [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
   logic [7:0] pq [$];
   time        pt [$];
   int         done_cnt = 0, errors = 0, checks = 0;

   funct_gen_sequencer #(.DATA_W(8), .ADDR_W(6), .REP_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_start_i (cfg_start),
      .cfg_last_i  (cfg_last),
      .cfg_we_i    (cfg_we),
      .cfg_data_i  (cfg_data),
      .gen_start_i (gen_start),
      .gen_stop_i  (gen_stop),
      .rep_i       (rep),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .fifo_full_i (fifo_full),
      .fifo_push_o (fifo_push),
      .fifo_data_o (fifo_data),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
      if (fifo_push) begin
         pq.push_back(fifo_data);
         pt.push_back($time);
      end
      if (done) done_cnt++;
   end

   task automatic test_reset();
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
      checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", fifo_push); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      @(negedge clk); rst = 1;
   endtask

   task automatic test_err_noconfig();
      @(negedge clk); gen_start = 1; #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL noconfig_err: got %b want 1", err); end
      @(negedge clk); gen_start = 0; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noconfig_busy: got %b want 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL noconfig_err_width: got %b want 0", err); end
   endtask

   task automatic test_config();
      int k = 0;
      @(negedge clk); cfg_start = 1; cfg_last = 6'd3;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); cfg_start = 0; cfg_last = 6'd9;
         cfg_we = c != 3; cfg_data = cfg_we ? wave[k] : 8'hee; #1;
         if (c == 1) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfg_busy: got %b want 1", busy); end
         end
         checks++; if (mem_we !== cfg_we) begin errors++; $display("FAIL cfg_we c%0d: got %b want %b", c, mem_we, cfg_we); end
         checks++; if (mem_addr !== 6'(k)) begin errors++; $display("FAIL cfg_addr c%0d: got %0d want %0d", c, mem_addr, k); end
         if (cfg_we) begin
            checks++; if (mem_wdata !== wave[k]) begin errors++; $display("FAIL cfg_wdata c%0d: got %h want %h", c, mem_wdata, wave[k]); end
            k++;
         end
      end
      @(negedge clk); cfg_we = 0; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_end_busy: got %b want 0", busy); end
   endtask

   task automatic test_gen_rep2();
      pq.delete(); pt.delete(); done_cnt = 0;
      @(negedge clk); gen_start = 1; rep = 8'd2;
      for (int c = 1; c <= 20; c++) begin @(negedge clk); gen_start = 0; end
      #1;
      checks++; if (pq.size() !== 8) begin errors++; $display("FAIL gen_count: got %0d want 8", pq.size()); end
      for (int i = 0; i < pq.size(); i++) begin
         checks++; if (pq[i] !== wave[i%4]) begin errors++; $display("FAIL gen_data[%0d]: got %h want %h", i, pq[i], wave[i%4]); end
      end
      for (int i = 1; i < pt.size(); i++) begin
         checks++; if (pt[i] - pt[i-1] !== 20) begin errors++; $display("FAIL gen_spacing[%0d]: got %0t want 20", i, pt[i] - pt[i-1]); end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL gen_done_pulses: got %0d want 1", done_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gen_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      pq.delete(); pt.delete(); done_cnt = 0;
      @(negedge clk); gen_start = 1; rep = 8'd1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); gen_start = 0; fifo_full = c >= 4 && c <= 8; #1;
         if (fifo_full) begin
            checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL bp_push_full c%0d: got %b want 0", c, fifo_push); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy c%0d: got %b want 1", c, busy); end
         end
      end
      fifo_full = 0;
      checks++; if (pq.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", pq.size()); end
      for (int i = 0; i < pq.size(); i++) begin
         checks++; if (pq[i] !== wave[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, pq[i], wave[i]); end
      end
      if (pt.size() >= 2) begin
         checks++; if (pt[1] - pt[0] !== 70) begin errors++; $display("FAIL bp_stall_gap: got %0t want 70", pt[1] - pt[0]); end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_stop();
      pq.delete(); pt.delete(); done_cnt = 0;
      @(negedge clk); gen_start = 1; rep = 8'd0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); gen_start = 0; gen_stop = c == 14; #1;
         if (c == 14) begin
            checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL stop_push: got %b want 0", fifo_push); end
         end
         if (c == 15) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle: got %b want 0", busy); end
         end
      end
      checks++; if (pq.size() !== 6) begin errors++; $display("FAIL stop_count: got %0d want 6", pq.size()); end
      for (int i = 0; i < pq.size(); i++) begin
         checks++; if (pq[i] !== wave[i%4]) begin errors++; $display("FAIL stop_data[%0d]: got %h want %h", i, pq[i], wave[i%4]); end
      end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL stop_done: got %0d want 0", done_cnt); end
   endtask

   task automatic test_busy_err();
      pq.delete(); pt.delete(); done_cnt = 0;
      @(negedge clk); gen_start = 1; rep = 8'd1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk); gen_start = 0; cfg_start = c == 3; #1;
         if (c == 3) begin
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL busy_err_pulse: got %b want 1", err); end
         end
         if (c == 4) begin
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL busy_err_clear: got %b want 0", err); end
         end
      end
      checks++; if (pq.size() !== 4) begin errors++; $display("FAIL busy_err_count: got %0d want 4", pq.size()); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_err_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_simultaneous();
      @(negedge clk); cfg_start = 1; gen_start = 1; cfg_last = 6'd3; rep = 8'd1; #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL simul_err: got %b want 0", err); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); cfg_start = 0; gen_start = 0; cfg_we = 1; cfg_data = wave[k]; #1;
         checks++; if (mem_we !== 1'b1 || mem_addr !== 6'(k)) begin errors++; $display("FAIL simul_cfg_write k%0d: got we=%b addr=%0d want we=1 addr=%0d", k, mem_we, mem_addr, k); end
         checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL simul_no_push k%0d: got %b want 0", k, fifo_push); end
      end
      @(negedge clk); cfg_we = 0; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_end_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_midgen();
      @(negedge clk); gen_start = 1; rep = 8'd0;
      for (int c = 1; c <= 5; c++) begin @(negedge clk); gen_start = 0; end
      #1;
      checks++; if (mem_addr !== 6'd2) begin errors++; $display("FAIL midgen_addr: got %0d want 2", mem_addr); end
      rst = 0; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midgen_rst_busy: got %b want 0", busy); end
      checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL midgen_rst_addr: got %0d want 0", mem_addr); end
      checks++; if (fifo_push !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL midgen_rst_strobes: got push=%b we=%b want 0 0", fifo_push, mem_we); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midgen_rst_flags: got done=%b err=%b want 0 0", done, err); end
      @(negedge clk); rst = 1;
      @(negedge clk); gen_start = 1; #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL midgen_err_after_rst: got %b want 1", err); end
      @(negedge clk); gen_start = 0; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midgen_stay_idle: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_err_noconfig();
      test_config();
      test_gen_rep2();
      test_backpressure();
      test_stop();
      test_busy_err();
      test_simultaneous();
      test_reset_midgen();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
